// File: rtl/masked_gf_mul_pipe.sv
// masked_gf_mul_pipe: two-share, first-order masked GF(2^W) multiplier,
// LANES independent lanes, two-stage valid/ready pipeline with
// randomness-availability gating and a saturating starvation counter.
// Optional build macro MASK_FLUSH_EN: a stage that drops to a bubble zeroes
// its data registers, so c0/c1 read 0 whenever out_valid is low.
module masked_gf_mul_pipe #(
  parameter int unsigned W     = 4,
  parameter logic [8:0]  POLY  = 9'h013,
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*W-1:0]     a0,
  input  logic [LANES*W-1:0]     a1,
  input  logic [LANES*W-1:0]     b0,
  input  logic [LANES*W-1:0]     b1,
  input  logic [LANES*2*W-1:0]   rnd,
  input  logic                   rnd_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*W-1:0]     c0,
  output logic [LANES*W-1:0]     c1,
  output logic [CNT_W-1:0]       starve_cnt
);

  localparam int unsigned DW = LANES * W;

  // Polynomial-basis product reduced by POLY (shift-and-add, reduce per shift)
  function automatic logic [W-1:0] gmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc;
    logic [W-1:0] sh;
    acc = '0;
    sh  = x;
    for (int unsigned i = 0; i < W; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = sh[W-1] ? (W'(sh << 1) ^ POLY[W-1:0]) : W'(sh << 1);
    end
    return acc;
  endfunction

  logic          v1, v2;
  logic [DW-1:0] a_q0, a_q1, rb_q0, rb_q1, i_q0, i_q1;
  logic [DW-1:0] rb_d0, rb_d1, i_d0, i_d1, c_d0, c_d1;
  logic          adv1_c, adv2_c, accept_c;

  // Handshake: a stage advances when it is empty or its successor advances
  assign adv2_c   = !v2 || out_ready;
  assign adv1_c   = !v1 || adv2_c;
  assign in_ready = adv1_c && rnd_valid;
  assign accept_c = in_valid && in_ready;
  assign out_valid = v2;

  // Per-lane datapath; cross-share operands are always r-masked before use
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W-1:0] r, z;
    assign r = rnd[k*2*W +: W];
    assign z = rnd[k*2*W+W +: W];
    assign rb_d0[k*W +: W] = b1[k*W +: W] ^ r;
    assign rb_d1[k*W +: W] = b0[k*W +: W] ^ r;
    assign i_d0[k*W +: W]  = gmul(a0[k*W +: W], b0[k*W +: W] ^ r) ^ z;
    assign i_d1[k*W +: W]  = gmul(a1[k*W +: W], b1[k*W +: W] ^ r) ^ z;
    assign c_d0[k*W +: W]  = gmul(a_q0[k*W +: W], rb_q0[k*W +: W]) ^ i_q0[k*W +: W];
    assign c_d1[k*W +: W]  = gmul(a_q1[k*W +: W], rb_q1[k*W +: W]) ^ i_q1[k*W +: W];
  end

  // Stage 1: register operand shares, refreshed cross shares, inner products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      a_q0  <= '0;
      a_q1  <= '0;
      rb_q0 <= '0;
      rb_q1 <= '0;
      i_q0  <= '0;
      i_q1  <= '0;
    end else if (adv1_c) begin
      v1 <= accept_c;
      if (accept_c) begin
        a_q0  <= a0;
        a_q1  <= a1;
        rb_q0 <= rb_d0;
        rb_q1 <= rb_d1;
        i_q0  <= i_d0;
        i_q1  <= i_d1;
      end
`ifdef MASK_FLUSH_EN
      else begin
        a_q0  <= '0;
        a_q1  <= '0;
        rb_q0 <= '0;
        rb_q1 <= '0;
        i_q0  <= '0;
        i_q1  <= '0;
      end
`endif
    end
  end

  // Stage 2: finish cross-domain products and register output shares
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      c0 <= '0;
      c1 <= '0;
    end else if (adv2_c) begin
      v2 <= v1;
      if (v1) begin
        c0 <= c_d0;
        c1 <= c_d1;
      end
`ifdef MASK_FLUSH_EN
      else begin
        c0 <= '0;
        c1 <= '0;
      end
`endif
    end
  end

  // Count cycles where only missing randomness blocks an otherwise-possible accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (in_valid && adv1_c && !rnd_valid && (starve_cnt != {CNT_W{1'b1}})) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_masked_gf_mul_pipe.sv
// Scoreboarded bench for masked_gf_mul_pipe (W=4, POLY=0x13, LANES=4, CNT_W=16).
module tb_masked_gf_mul_pipe;

  localparam int unsigned W      = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DW     = LANES * W;
  localparam int unsigned RW     = LANES * 2 * W;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned POLY_I = 32'h13;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [RW-1:0]   rnd = '0;
  logic            rnd_valid = 1'b1;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   c0, c1;
  logic [CNT_W-1:0] starve_cnt;

  always #5 clk = ~clk;

  masked_gf_mul_pipe #(.W(W), .POLY(9'h013), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .rnd(rnd), .rnd_valid(rnd_valid),
    .out_valid(out_valid), .out_ready(out_ready), .c0(c0), .c1(c1),
    .starve_cnt(starve_cnt)
  );

  typedef struct {
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    int unsigned   acc_cyc;
    bit            lat_chk;
  } exp_t;

  exp_t          q[$];
  int unsigned   cyc = 0;
  int            n_test = 0;
  int            n_fail = 0;
  bit            lat_mode = 1'b0;
  logic [DW-1:0] last_c0 = '0, last_c1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: carry-less product, then long division by the field polynomial
  function automatic int unsigned ref_gmul(int unsigned x, int unsigned y);
    int unsigned p = 0;
    for (int i = 0; i < int'(W); i++)
      if (((y >> i) & 1) != 0) p = p ^ (x << i);
    for (int i = 2*int'(W)-2; i >= int'(W); i--)
      if (((p >> i) & 1) != 0) p = p ^ (POLY_I << (i - int'(W)));
    return p;
  endfunction

  // Each output share is a_i * (b0^b1) masked by the lane's z
  function automatic exp_t make_exp();
    exp_t e;
    int unsigned msk, xa0, xa1, xb, xz;
    msk = (1 << W) - 1;
    e.c0 = '0;
    e.c1 = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      xa0 = (int'(a0) >> (k*W)) & msk;
      xa1 = (int'(a1) >> (k*W)) & msk;
      xb  = ((int'(b0) ^ int'(b1)) >> (k*W)) & msk;
      xz  = (rnd >> (k*2*W + W)) & msk;
      e.c0[k*W +: W] = W'(ref_gmul(xa0, xb) ^ xz);
      e.c1[k*W +: W] = W'(ref_gmul(xa1, xb) ^ xz);
    end
    e.acc_cyc = cyc;
    e.lat_chk = lat_mode;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: sample handshake at negedge, enqueue expected result on accept
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = rst_n && in_valid && in_ready;
    e = make_exp();
    @(posedge clk);
    if (acc) q.push_back(e);
    #1;
  endtask

  task automatic rand_ops();
    a0  = DW'($urandom);
    a1  = DW'($urandom);
    b0  = DW'($urandom);
    b1  = DW'($urandom);
    rnd = RW'($urandom);
  endtask

  // Monitor: occupancy-based ready, starvation model, scoreboard pop, hold/bubble
  logic [CNT_W-1:0] st_model = '0;
  bit               held = 1'b0;
  logic [DW-1:0]    hc0 = '0, hc1 = '0;
  always @(negedge clk) begin
    exp_t e;
    bit   room;
    if (!rst_n) begin
      st_model = '0;
      held     = 1'b0;
      last_c0  = '0;
      last_c1  = '0;
    end else begin
      room = (q.size() < 2) || out_ready;
      check("in_ready", 64'(in_ready), 64'(room && rnd_valid));
      check("starve_cnt", 64'(starve_cnt), 64'(st_model));
      if (in_valid && room && !rnd_valid && st_model != {CNT_W{1'b1}}) st_model = st_model + 1'b1;
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_c0", 64'(c0), 64'(hc0));
        check("hold_c1", 64'(c1), 64'(hc1));
      end
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            n_test++;
            n_fail++;
            $display("FAIL spurious_out: got out_valid=1 expected empty pipeline (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            check("c0", 64'(c0), 64'(e.c0));
            check("c1", 64'(c1), 64'(e.c1));
            if (e.lat_chk) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
          end
          last_c0 = c0;
          last_c1 = c1;
        end
      end else begin
`ifdef MASK_FLUSH_EN
        check("bubble_c0", 64'(c0), 64'd0);
        check("bubble_c1", 64'(c1), 64'd0);
`else
        check("bubble_c0", 64'(c0), 64'(last_c0));
        check("bubble_c1", 64'(c1), 64'(last_c1));
`endif
      end
      held = out_valid && !out_ready;
      hc0  = c0;
      hc1  = c1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c0", 64'(c0), 64'd0);
    check("rst_c1", 64'(c1), 64'd0);
    check("rst_starve", 64'(starve_cnt), 64'd0);
    rst_n = 1'b1;

    // Single known product: a=3, b=7, r=A, z=4 in every lane
    lat_mode = 1'b1;
    a0 = {LANES{4'h5}}; a1 = {LANES{4'h6}};
    b0 = {LANES{4'hC}}; b1 = {LANES{4'hB}};
    rnd = {LANES{8'h4A}};
    in_valid = 1'b1;
    step(acc);
    check("single_acc", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (4) step(acc);
    lat_mode = 1'b0;
    check("single_c0", 64'(last_c0), 64'hCCCC);
    check("single_xor", 64'(last_c0 ^ last_c1), 64'h9999);

    // Reduction: a=8, b=2 in random split shares
    rand_ops();
    a1 = a0 ^ {LANES{4'h8}};
    b1 = b0 ^ {LANES{4'h2}};
    in_valid = 1'b1;
    step(acc);
    in_valid = 1'b0;
    repeat (4) step(acc);
    check("reduce_xor", 64'(last_c0 ^ last_c1), 64'h3333);

    // Fill both stages under backpressure, then reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin rand_ops(); step(acc); end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_c0", 64'(c0), 64'd0);
    check("mid_rst_c1", 64'(c1), 64'd0);
    check("mid_rst_starve", 64'(starve_cnt), 64'd0);
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    rand_ops();
    in_valid = 1'b1;
    step(acc);
    check("post_rst_acc", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (3) step(acc);
    lat_mode = 1'b0;

    // Starvation on an empty pipeline
    in_valid  = 1'b1;
    rnd_valid = 1'b0;
    repeat (5) begin step(acc); check("starve_no_acc", 64'(acc), 64'd0); end
    check("starve5", 64'(starve_cnt), 64'd5);
    rnd_valid = 1'b1;
    rand_ops();
    step(acc);
    check("starve_acc", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (3) step(acc);

    // Backpressure: 6 operands, output stalled for 4 cycles from the 2nd result
    sent = 0;
    rand_ops();
    for (int s = 0; s < 40 && (sent < 6 || q.size() > 0); s++) begin
      in_valid  = (sent < 6);
      out_ready = !(s >= 3 && s < 7);
      step(acc);
      if (acc) begin sent++; rand_ops(); end
    end
    check("bp_sent", 64'(sent), 64'd6);
    check("bp_drained", 64'(q.size()), 64'd0);

    // Randomized traffic
    sent = 0;
    for (int s = 0; s < 5000 && sent < 1000; s++) begin
      rand_ops();
      in_valid  = ($urandom_range(0, 9) < 8);
      rnd_valid = ($urandom_range(0, 9) < 9);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) sent++;
    end
    check("rand_sent", 64'(sent), 64'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rnd_valid = 1'b1;
    for (int s = 0; s < 20 && q.size() > 0; s++) step(acc);
    check("rand_drained", 64'(q.size()), 64'd0);
    repeat (3) step(acc);
`ifdef MASK_FLUSH_EN
    check("idle_c0", 64'(c0), 64'd0);
    check("idle_c1", 64'(c1), 64'd0);
`else
    check("idle_c0", 64'(c0), 64'(last_c0));
    check("idle_c1", 64'(c1), 64'(last_c1));
`endif

    // Saturation of the starvation counter
    in_valid  = 1'b1;
    rnd_valid = 1'b0;
    repeat (65540) step(acc);
    check("starve_sat", 64'(starve_cnt), 64'hFFFF);
    in_valid = 1'b0;
    step(acc);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
